// File: rtl/seq_detector_param.sv
// Purpose: serial-bit sequence detector with a loadable pattern and a saturating match counter.
// Latency: out is high in the cycle after the edge that samples the completing bit.
// Backpressure: none; bits are qualified by en, load flushes history and wins over en.
module seq_detector_param #(
    parameter int                 PAT_LEN       = 4,
    parameter int                 CNT_W         = 8,
    parameter logic [PAT_LEN-1:0] RESET_PATTERN = PAT_LEN'(4'b1011)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               x,
    input  logic               overlap,
    input  logic               load,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               count_clr,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    // fill has to reach PAT_LEN inclusive
    localparam int FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

    logic [PAT_LEN-1:0] r_pat;
    logic [PAT_LEN-1:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic               r_out;
    logic [CNT_W-1:0]   r_cnt;

    logic [PAT_LEN-1:0] w_hist_n;
    logic [FILL_W-1:0]  w_fill_n;
    logic               w_cmp;
    logic               w_match;
    logic               w_cnt_max;

    // Next history and fill for an accepted bit; a match needs a full window
    // so a zeroed history never matches an all-zero pattern early.
    always_comb begin
        w_hist_n = {r_hist[PAT_LEN-2:0], x};
        w_fill_n = (r_fill == FILL_FULL) ? r_fill : r_fill + FILL_W'(1);
        w_cmp    = (w_fill_n == FILL_FULL) && (w_hist_n == r_pat);
        w_match  = en && !load && w_cmp;
    end

    assign w_cnt_max = (r_cnt == {CNT_W{1'b1}});

    // Pattern, history, fill and match pulse; load discards the bit of its cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat  <= RESET_PATTERN;
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (load) begin
            r_pat  <= pattern_in;
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else if (en) begin
            r_hist <= w_hist_n;
            // non-overlap restarts the window so the matched bits are not reused
            r_fill <= (w_match && !overlap) ? '0 : w_fill_n;
            r_out  <= w_match;
        end else begin
            r_out  <= 1'b0;
        end
    end

    // Saturating match counter; clear beats a same-cycle match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (count_clr) begin
            r_cnt <= '0;
        end else if (w_match && !w_cnt_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out         = r_out;
    assign match_count = r_cnt;
    assign count_sat   = w_cnt_max;

endmodule

// File: tb/tb_seq_detector_param.sv
// Purpose: directed self-checking bench for seq_detector_param (PAT_LEN=4, CNT_W=2).
// Latency: inputs applied after one edge take effect at the next; outputs sampled 1ns after it.
// Backpressure: n/a.
module tb_seq_detector_param;

    logic       clk;
    logic       rst;
    logic       en;
    logic       x;
    logic       overlap;
    logic       load;
    logic [3:0] pattern_in;
    logic       count_clr;
    logic       out;
    logic [1:0] match_count;
    logic       count_sat;

    int n_cmp = 0;
    int n_err = 0;

    seq_detector_param #(
        .PAT_LEN       (4),
        .CNT_W         (2),
        .RESET_PATTERN (4'b1011)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .x           (x),
        .overlap     (overlap),
        .load        (load),
        .pattern_in  (pattern_in),
        .count_clr   (count_clr),
        .out         (out),
        .match_count (match_count),
        .count_sat   (count_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic b);
        en = 1'b1;
        x  = b;
        tick();
        en = 1'b0;
    endtask

    task automatic idle(input logic b);
        en = 1'b0;
        x  = b;
        tick();
    endtask

    task automatic do_load(input logic [3:0] p, input logic clr);
        load       = 1'b1;
        pattern_in = p;
        count_clr  = clr;
        en         = 1'b0;
        tick();
        load       = 1'b0;
        count_clr  = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        en         = 1'b1;
        x          = 1'b1;
        overlap    = 1'b1;
        load       = 1'b0;
        pattern_in = 4'b0000;
        count_clr  = 1'b0;

        // reset state
        tick();
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_cnt", 32'(match_count), 32'd0);
        chk("rst_sat", 32'(count_sat), 32'd0);
        rst = 1'b0;
        en  = 1'b0;

        // basic match with reset pattern 1011
        send(1'b1); chk("basic_b1", 32'(out), 32'd0);
        send(1'b0); chk("basic_b2", 32'(out), 32'd0);
        send(1'b1); chk("basic_b3", 32'(out), 32'd0);
        send(1'b1); chk("basic_b4", 32'(out), 32'd1);
        chk("basic_cnt", 32'(match_count), 32'd1);
        idle(1'b0); chk("basic_pulse_end", 32'(out), 32'd0);

        // overlap stream 1011011
        overlap = 1'b1;
        do_load(4'b1011, 1'b1);
        chk("ovl_load_out", 32'(out), 32'd0);
        chk("ovl_load_cnt", 32'(match_count), 32'd0);
        send(1'b1); chk("ovl_b1", 32'(out), 32'd0);
        send(1'b0); chk("ovl_b2", 32'(out), 32'd0);
        send(1'b1); chk("ovl_b3", 32'(out), 32'd0);
        send(1'b1); chk("ovl_b4", 32'(out), 32'd1);
        send(1'b0); chk("ovl_b5", 32'(out), 32'd0);
        send(1'b1); chk("ovl_b6", 32'(out), 32'd0);
        send(1'b1); chk("ovl_b7", 32'(out), 32'd1);
        chk("ovl_cnt", 32'(match_count), 32'd2);

        // non-overlap stream 1011011
        overlap = 1'b0;
        do_load(4'b1011, 1'b1);
        send(1'b1); send(1'b0); send(1'b1);
        send(1'b1); chk("novl_b4", 32'(out), 32'd1);
        send(1'b0); chk("novl_b5", 32'(out), 32'd0);
        send(1'b1); chk("novl_b6", 32'(out), 32'd0);
        send(1'b1); chk("novl_b7", 32'(out), 32'd0);
        chk("novl_cnt", 32'(match_count), 32'd1);

        // fill gating with an all-zero pattern
        overlap = 1'b1;
        do_load(4'b0000, 1'b1);
        send(1'b0); chk("fill_b1", 32'(out), 32'd0);
        send(1'b0); chk("fill_b2", 32'(out), 32'd0);
        send(1'b0); chk("fill_b3", 32'(out), 32'd0);
        send(1'b0); chk("fill_b4", 32'(out), 32'd1);
        send(1'b0); chk("fill_b5", 32'(out), 32'd1);
        chk("fill_cnt", 32'(match_count), 32'd2);

        // enable gaps
        do_load(4'b1011, 1'b1);
        send(1'b1); chk("gap_b1", 32'(out), 32'd0);
        send(1'b0); chk("gap_b2", 32'(out), 32'd0);
        idle(1'b1); chk("gap_idle1", 32'(out), 32'd0);
        idle(1'b0); chk("gap_idle2", 32'(out), 32'd0);
        idle(1'b1); chk("gap_idle3", 32'(out), 32'd0);
        send(1'b1); chk("gap_b3", 32'(out), 32'd0);
        send(1'b1); chk("gap_b4", 32'(out), 32'd1);
        chk("gap_cnt", 32'(match_count), 32'd1);

        // saturation of the 2-bit counter, then clear against a match
        do_load(4'b1011, 1'b1);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        chk("sat_m1", 32'(match_count), 32'd1);
        send(1'b0); send(1'b1); send(1'b1);
        chk("sat_m2_cnt", 32'(match_count), 32'd2);
        chk("sat_m2_sat", 32'(count_sat), 32'd0);
        send(1'b0); send(1'b1); send(1'b1);
        chk("sat_m3_cnt", 32'(match_count), 32'd3);
        chk("sat_m3_sat", 32'(count_sat), 32'd1);
        send(1'b0); send(1'b1); send(1'b1);
        chk("sat_m4_out", 32'(out), 32'd1);
        chk("sat_m4_cnt", 32'(match_count), 32'd3);
        chk("sat_m4_sat", 32'(count_sat), 32'd1);
        send(1'b0); send(1'b1);
        count_clr = 1'b1;
        send(1'b1);
        count_clr = 1'b0;
        chk("clr_m5_out", 32'(out), 32'd1);
        chk("clr_m5_cnt", 32'(match_count), 32'd0);
        chk("clr_m5_sat", 32'(count_sat), 32'd0);

        // reset mid-stream restores the 1011 pattern and clears history
        do_load(4'b0111, 1'b0);
        send(1'b1); send(1'b0); send(1'b1);
        rst = 1'b1;
        send(1'b1);
        rst = 1'b0;
        chk("rstmid_out", 32'(out), 32'd0);
        chk("rstmid_cnt", 32'(match_count), 32'd0);
        send(1'b1); chk("rstmid_b1", 32'(out), 32'd0);
        send(1'b0); chk("rstmid_b2", 32'(out), 32'd0);
        send(1'b1); chk("rstmid_b3", 32'(out), 32'd0);
        send(1'b1); chk("rstmid_b4", 32'(out), 32'd1);
        chk("rstmid_cnt2", 32'(match_count), 32'd1);

        // load mid-stream discards its own bit and keeps the counter
        send(1'b1); send(1'b0); send(1'b1);
        load       = 1'b1;
        pattern_in = 4'b0111;
        send(1'b1);
        load       = 1'b0;
        chk("ldmid_out", 32'(out), 32'd0);
        chk("ldmid_cnt", 32'(match_count), 32'd1);
        send(1'b0); chk("ldmid_b1", 32'(out), 32'd0);
        send(1'b1); chk("ldmid_b2", 32'(out), 32'd0);
        send(1'b1); chk("ldmid_b3", 32'(out), 32'd0);
        send(1'b1); chk("ldmid_b4", 32'(out), 32'd1);
        chk("ldmid_cnt2", 32'(match_count), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
